// File: rtl/fxp_mult_lanes_if.sv
// Beat/result bundle for fxp_mult_lanes: packed lane operands in, packed lane
// results with per-lane saturation flags out.
interface fxp_mult_lanes_if #(
    parameter int dataWidth = 16,
    parameter int lanes     = 4
);
    logic                         in_valid;
    logic                         mode;
    logic                         in_last;
    logic [lanes*dataWidth-1:0]   a;
    logic [lanes*dataWidth-1:0]   b;
    logic                         out_valid;
    logic [lanes*dataWidth-1:0]   out_data;
    logic [lanes-1:0]             out_sat;

    modport master (
        output in_valid, mode, in_last, a, b,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, mode, in_last, a, b,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fxp_mult_lanes.sv
// Five-stage multi-lane signed fixed-point multiplier with round/saturate and
// an accumulate mode that reduces all lane products over a packet into lane 0.
module fxp_mult_lanes #(
    parameter int dataWidth = 16,
    parameter int fracWidth = 14,
    parameter int lanes     = 4,
    parameter int accWidth  = 40
) (
    input  logic              clk,
    input  logic              rst,
    fxp_mult_lanes_if.slave   io_bus
);
    localparam int DW = dataWidth;
    localparam int PW = 2 * dataWidth;
    localparam int AW = accWidth;
    localparam int LW = lanes * dataWidth;

    localparam logic signed [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (fracWidth - 1);
    localparam logic signed [AW:0] MAXV = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef logic signed [PW-1:0] prod_t;

    // Round half-up at the binary point, then clamp; MSB of result is the clip flag.
    function automatic logic [DW:0] round_sat(input logic signed [AW-1:0] x);
        logic signed [AW:0] t;
        logic [DW:0]        res;
        t = ($signed({x[AW-1], x}) + HALF) >>> fracWidth;
        if (t > MAXV) begin
            res = {1'b1, MAXV[DW-1:0]};
        end else if (t < MINV) begin
            res = {1'b1, MINV[DW-1:0]};
        end else begin
            res = {1'b0, t[DW-1:0]};
        end
        return res;
    endfunction

    logic                   r_s1_valid, r_s1_mode, r_s1_last;
    logic [LW-1:0]          r_s1_a, r_s1_b;
    logic                   r_s2_valid, r_s2_mode, r_s2_last;
    prod_t                  r_s2_p [lanes];
    logic                   r_s3_valid, r_s3_mode, r_s3_last;
    prod_t                  r_s3_p [lanes];
    logic signed [AW-1:0]   r_s3_s;
    logic                   r_s4_valid, r_s4_mode, r_s4_last;
    prod_t                  r_s4_p [lanes];
    logic signed [AW-1:0]   r_acc;
    logic                   r_first;
    logic                   r_out_valid;
    logic [LW-1:0]          r_out_data;
    logic [lanes-1:0]       r_out_sat;

    logic signed [DW-1:0]   w_a [lanes];
    logic signed [DW-1:0]   w_b [lanes];
    prod_t                  w_p [lanes];
    logic signed [AW-1:0]   w_s;
    logic signed [AW-1:0]   w_acc_next;
    logic signed [AW-1:0]   w_x [lanes];
    logic                   w_emit;
    logic [LW-1:0]          w_data;
    logic [lanes-1:0]       w_sat;

    // Products, lane sum, accumulator update and output rounding.
    always_comb begin
        w_s        = '0;
        w_data     = '0;
        w_sat      = '0;
        for (int i = 0; i < lanes; i++) begin
            w_a[i] = r_s1_a[i*DW +: DW];
            w_b[i] = r_s1_b[i*DW +: DW];
            w_p[i] = PW'(w_a[i]) * PW'(w_b[i]);
            w_s    = w_s + AW'(r_s2_p[i]);
        end
        w_acc_next = (r_first ? {AW{1'b0}} : r_acc) + r_s3_s;
        w_emit     = r_s4_valid & (~r_s4_mode | r_s4_last);
        // Accumulate results land in lane 0; the other lanes round 0 to 0, unclipped.
        for (int i = 0; i < lanes; i++) begin
            if (r_s4_mode) begin
                w_x[i] = (i == 0) ? r_acc : {AW{1'b0}};
            end else begin
                w_x[i] = AW'(r_s4_p[i]);
            end
            {w_sat[i], w_data[i*DW +: DW]} = round_sat(w_x[i]);
        end
    end

    // Pipeline stages S1..S4 (data and control).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_s1_valid, r_s1_mode, r_s1_last} <= 3'b000;
            {r_s2_valid, r_s2_mode, r_s2_last} <= 3'b000;
            {r_s3_valid, r_s3_mode, r_s3_last} <= 3'b000;
            {r_s4_valid, r_s4_mode, r_s4_last} <= 3'b000;
            r_s1_a <= '0;
            r_s1_b <= '0;
            r_s3_s <= '0;
            for (int i = 0; i < lanes; i++) begin
                r_s2_p[i] <= '0;
                r_s3_p[i] <= '0;
                r_s4_p[i] <= '0;
            end
        end else begin
            {r_s1_valid, r_s1_mode, r_s1_last} <= {io_bus.in_valid, io_bus.mode, io_bus.in_last};
            {r_s2_valid, r_s2_mode, r_s2_last} <= {r_s1_valid, r_s1_mode, r_s1_last};
            {r_s3_valid, r_s3_mode, r_s3_last} <= {r_s2_valid, r_s2_mode, r_s2_last};
            {r_s4_valid, r_s4_mode, r_s4_last} <= {r_s3_valid, r_s3_mode, r_s3_last};
            r_s1_a <= io_bus.a;
            r_s1_b <= io_bus.b;
            r_s3_s <= w_s;
            for (int i = 0; i < lanes; i++) begin
                r_s2_p[i] <= w_p[i];
                r_s3_p[i] <= r_s2_p[i];
                r_s4_p[i] <= r_s3_p[i];
            end
        end
    end

    // Packet accumulator; elementwise beats and bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (r_s3_valid && r_s3_mode) begin
            r_acc   <= w_acc_next;
            r_first <= r_s3_last;
        end else begin
            r_acc   <= r_acc;
            r_first <= r_first;
        end
    end

    // Output registers: strobe for one cycle, hold data between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_data <= w_data;
                r_out_sat  <= w_sat;
            end else begin
                r_out_data <= r_out_data;
                r_out_sat  <= r_out_sat;
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_fxp_mult_lanes.sv
// Bench for fxp_mult_lanes: fixed vectors, hand sequences for reset/interleave
// corners and random beats scored against an arithmetic model of the beat rules.
module tb_fxp_mult_lanes;
    localparam int DW = 16;
    localparam int F  = 14;
    localparam int L  = 4;
    localparam int AW = 40;
    localparam int LW = L * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fxp_mult_lanes_if #(.dataWidth(DW), .lanes(L)) bus ();

    fxp_mult_lanes #(.dataWidth(DW), .fracWidth(F), .lanes(L), .accWidth(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        longint         due;
        logic [LW-1:0]  data;
        logic [L-1:0]   sat;
    } exp_t;

    typedef struct {
        logic           mode;
        logic           last;
        logic [LW-1:0]  a;
        logic [LW-1:0]  b;
        logic           emit;
        logic [LW-1:0]  data;
        logic [L-1:0]   sat;
    } vec_t;

    exp_t           exp_q[$];
    vec_t           tab[10];
    int             n_cmp = 0;
    int             n_bad = 0;
    longint         edge_n = 0;
    logic [LW-1:0]  hold_data;
    logic [L-1:0]   hold_sat;
    longint         m_acc;
    logic           m_first;

    always @(posedge clk) edge_n <= edge_n + 64'sd1;

    task automatic cmp(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h want %h", name, edge_n, got, want);
        end
    endtask

    function automatic void rs(input longint x, output logic [DW-1:0] d, output logic s);
        longint r;
        r = (x + 64'sd8192) >>> F;
        if (r > 64'sd32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (r < -64'sd32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = r[15:0];  s = 1'b0;
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_acc     = 64'sd0;
        m_first   = 1'b1;
        hold_data = '0;
        hold_sat  = '0;
    endtask

    // One accepted beat: result due at the negedge after the fifth rising edge.
    task automatic model_beat(input logic m, input logic l, input logic [LW-1:0] av,
                              input logic [LW-1:0] bv, input logic ov,
                              input logic [LW-1:0] od, input logic [L-1:0] os);
        exp_t               e;
        longint             p[L];
        longint             sum;
        logic signed [DW-1:0] ai, bi;
        logic [DW-1:0]      d;
        logic               s;
        logic               push;
        sum = 64'sd0;
        for (int i = 0; i < L; i++) begin
            ai = av[i*DW +: DW];
            bi = bv[i*DW +: DW];
            p[i] = longint'(ai) * longint'(bi);
            sum += p[i];
        end
        e.due  = edge_n + 64'sd5;
        e.data = '0;
        e.sat  = '0;
        push   = 1'b0;
        if (!m) begin
            for (int i = 0; i < L; i++) begin
                rs(p[i], d, s);
                e.data[i*DW +: DW] = d;
                e.sat[i] = s;
            end
            push = 1'b1;
        end else begin
            m_acc   = (m_first ? 64'sd0 : m_acc) + sum;
            m_acc   = (m_acc <<< (64 - AW)) >>> (64 - AW);
            m_first = l;
            if (l) begin
                rs(m_acc, d, s);
                e.data[DW-1:0] = d;
                e.sat[0] = s;
                push = 1'b1;
            end
        end
        if (push) begin
            if (ov) begin
                e.data = od;
                e.sat  = os;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        cmp("out_valid", LW'(bus.out_valid), LW'(ev));
        if (ev) begin
            hold_data = exp_q[0].data;
            hold_sat  = exp_q[0].sat;
            void'(exp_q.pop_front());
        end
        cmp("out_data", bus.out_data, hold_data);
        cmp("out_sat", LW'(bus.out_sat), LW'(hold_sat));
    endtask

    task automatic beat(input logic v, input logic m, input logic l,
                        input logic [LW-1:0] av, input logic [LW-1:0] bv,
                        input logic ov, input logic [LW-1:0] od, input logic [L-1:0] os);
        @(negedge clk);
        check_outputs();
        bus.in_valid = v;
        bus.mode     = m;
        bus.in_last  = l;
        bus.a        = av;
        bus.b        = bv;
        if (v) model_beat(m, l, av, bv, ov, od, os);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;
    endtask

    function automatic logic [LW-1:0] rand_vec();
        logic [LW-1:0] v;
        logic [DW-1:0] w;
        for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 5))
                0:       w = 16'h8000;
                1:       w = 16'h7FFF;
                default: w = 16'($urandom());
            endcase
            v[i*DW +: DW] = w;
        end
        return v;
    endfunction

    localparam logic [LW-1:0] A_HALF = {4{16'h4000}};
    localparam logic [LW-1:0] B_SMALL = {4{16'h0800}};

    initial begin
        bus.in_valid = 1'b0; bus.mode = 1'b0; bus.in_last = 1'b0;
        bus.a = '0; bus.b = '0;
        model_reset();
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b0;

        tab[0] = '{1'b0, 1'b0, {32'h0, 16'h8000, 16'h2000}, {32'h0, 16'h8000, 16'h2000},
                   1'b1, {32'h0, 16'h7FFF, 16'h1000}, 4'b0010};
        tab[1] = '{1'b0, 1'b0, {32'h0, 16'hFFFD, 16'h0003}, {32'h0, 16'h2000, 16'h2000},
                   1'b1, {32'h0, 16'hFFFF, 16'h0002}, 4'b0000};
        tab[2] = '{1'b0, 1'b0, {16'hC000, 16'h8000, 32'h0}, {16'h4000, 16'h7FFF, 32'h0},
                   1'b1, {16'hC000, 16'h8000, 32'h0}, 4'b0100};
        tab[3] = '{1'b0, 1'b0, {32'h0, 16'h0001, 16'hFFFF}, {32'h0, 16'h2000, 16'h2000},
                   1'b1, {32'h0, 16'h0001, 16'h0000}, 4'b0000};
        tab[4] = '{1'b1, 1'b0, A_HALF, B_SMALL, 1'b0, 64'h0, 4'b0000};
        tab[5] = '{1'b1, 1'b1, A_HALF, B_SMALL, 1'b1, {48'h0, 16'h4000}, 4'b0000};
        tab[6] = '{1'b1, 1'b0, A_HALF, {4{16'h1000}}, 1'b0, 64'h0, 4'b0000};
        tab[7] = '{1'b1, 1'b0, A_HALF, {4{16'h1000}}, 1'b0, 64'h0, 4'b0000};
        tab[8] = '{1'b1, 1'b1, A_HALF, {4{16'h1000}}, 1'b1, {48'h0, 16'h7FFF}, 4'b0001};
        tab[9] = '{1'b1, 1'b1, {4{16'hC000}}, {4{16'h4000}}, 1'b1, {48'h0, 16'h8000}, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, tab[i].mode, tab[i].last, tab[i].a, tab[i].b,
                 tab[i].emit, tab[i].data, tab[i].sat);
        end
        repeat (6) idle();

        // Elementwise beat and a bubble inside an open packet.
        beat(1'b1, 1'b1, 1'b0, A_HALF, B_SMALL, 1'b0, '0, '0);
        beat(1'b1, 1'b0, 1'b1, rand_vec(), rand_vec(), 1'b0, '0, '0);
        idle();
        beat(1'b1, 1'b1, 1'b1, A_HALF, B_SMALL, 1'b1, {48'h0, 16'h4000}, 4'b0000);
        // Back-to-back single-beat packets.
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec(), 1'b0, '0, '0);
        end
        repeat (6) idle();

        // Reset with a partial packet and an elementwise beat in flight.
        beat(1'b1, 1'b1, 1'b0, A_HALF, B_SMALL, 1'b0, '0, '0);
        beat(1'b1, 1'b0, 1'b0, rand_vec(), rand_vec(), 1'b0, '0, '0);
        do_reset();
        beat(1'b1, 1'b1, 1'b1, A_HALF, B_SMALL, 1'b1, {48'h0, 16'h2000}, 4'b0000);
        repeat (6) idle();

        for (int i = 0; i < 400; i++) begin
            beat(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), rand_vec(), rand_vec(), 1'b0, '0, '0);
        end
        beat(1'b1, 1'b1, 1'b1, rand_vec(), rand_vec(), 1'b0, '0, '0);
        repeat (8) idle();
        cmp("pending_results", LW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fxp_mult_lanes.md
# fxp_mult_lanes

Multi-lane, fully pipelined signed fixed-point multiplier with round-and-saturate output and an optional dot-product accumulate mode. It is the parametrised successor of the single-lane registered multiplier used in the LSTM gate datapath:

- **Elementwise mode:** returns `lanes` products, rescaled to the same Q format as the inputs.
- **Accumulate mode:** sums all lane products over a multi-beat packet, so one instance computes a weight-row × input-vector dot product for a gate pre-activation.

There is no backpressure; downstream must accept every `out_valid` pulse.

## Interface
Parameters:
- `dataWidth`, 16: operand and result width, signed two's complement.
- `fracWidth`, 14: fractional bits of operands and result (Q(dataWidth−fracWidth).fracWidth). Must satisfy 1 ≤ fracWidth < dataWidth.
- `lanes`, 4: number of parallel multipliers, ≥ 1.
- `accWidth`, 40: accumulator width. Must be ≥ 2·dataWidth + ceil(log2(lanes)).

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: the beat on `a`/`b`/`mode`/`in_last` is valid this cycle.
- `mode`, in, 1: 0 = elementwise, 1 = accumulate. Sampled per beat.
- `in_last`, in, 1: final beat of an accumulate packet. Ignored when `mode`=0.
- `a`, in, lanes·dataWidth: lane i occupies bits [i·dataWidth +: dataWidth], signed.
- `b`, in, lanes·dataWidth: same packing as `a`, signed.
- `out_valid`, out, 1: single-cycle result strobe.
- `out_data`, out, lanes·dataWidth: results, same packing as the inputs.
- `out_sat`, out, lanes: per-lane flag; 1 = the result in that lane was clipped.

## Operation
Pipeline stages; every beat traverses all five regardless of mode:
- **S1:** register `a`, `b`, `mode`, `in_last`, `in_valid`.
- **S2:** per-lane full-precision signed product p_i, 2·dataWidth bits.
- **S3:** lane sum s = Σ p_i, sign-extended to accWidth. The p_i are carried alongside.
- **S4:**
  - Accumulate beat: acc ← (first ? 0 : acc) + s. first ← in_last.
  - Elementwise beat: p_i carried; acc and first untouched.
- **S5:** round and saturate into the output registers, then assert `out_valid`.
  - Elementwise beat: x_i = p_i.
  - Accumulate beat with in_last=1: x_0 = acc (post-S4 value); lanes 1..lanes−1 output 0 with out_sat=0.
  - Accumulate beat with in_last=0: no output; `out_valid` stays 0.
- **Round:** r = (x + 2^(fracWidth−1)) >>> fracWidth (arithmetic shift, round-half-up toward +∞).
- **Saturate:** clamp r to [−2^(dataWidth−1), 2^(dataWidth−1)−1]. out_sat_i = 1 iff clamping occurred.
- **Accumulator overflow:** wraps modulo 2^accWidth, undetected. Sizing is the integrator's responsibility.
- **Interleaving:** elementwise beats may be interleaved inside an open accumulate packet without disturbing acc or first.
- **Single-beat packets:** an accumulate beat with in_last=1 while first=1 is a complete one-beat packet.
- **Unterminated packet:** accumulate beats with no in_last keep summing indefinitely.
- **Reset** (asynchronous, any time, including mid-packet):
  - All stage valid bits, data registers and acc clear to 0; first ← 1.
  - `out_valid`=0, `out_data`=0, `out_sat`=0.
  - In-flight beats are discarded; no partial result is emitted after reset releases.

## Timing
- Latency: a beat sampled at edge k produces `out_valid`=1 in the cycle after edge k+4, i.e. 5 cycles. Identical for both modes, so outputs never collide.
- Throughput: one beat per cycle, sustained, in either mode.
- `out_valid` is high for exactly one cycle per emitting beat. `out_data`/`out_sat` hold their last value while `out_valid`=0.
- Back-to-back packets: a new packet may start the cycle after in_last with no bubble. Its first beat restarts acc from 0.
- Bubbles (`in_valid`=0) are permitted inside a packet; acc holds through them.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` for 3 cycles, with and without a packet in flight → `out_valid`=0, `out_data`=0, `out_sat`=0. The first packet after release sums from 0.
- **Elementwise scaling and saturation:** mode=0, lane0 a=b=8192 (0.5), lane1 a=b=−32768 → 5 cycles later lane0=4096, out_sat[0]=0; lane1=32767, out_sat[1]=1.
- **Rounding:** mode=0, lane0 a=3, b=8192 and lane1 a=−3, b=8192 → lane0=2, lane1=−1, no saturation.
- **Accumulate:** 2 beats, all lanes a=16384, b=2048, last on beat 2 → single strobe 5 cycles after beat 2 with lane0=16384, other lanes 0. Repeat with 3 beats and b=4096 → lane0=32767, out_sat[0]=1.
- **Interleave and streaming:**
  - Accumulate packet with an elementwise beat and an idle bubble inserted mid-packet → the elementwise result appears at its own latency, and the packet sum is unchanged.
  - Back-to-back 1-beat packets → one strobe per cycle with independent sums.
- **Mid-packet reset:** reset after beat 1 of a 3-beat packet, then a fresh 1-beat packet → only the fresh packet's result appears.
